// File: rtl/hex_keypad_scanner.sv
// Hex keypad scanner. It scans a 4x4 matrix keypad one column at a time and
// debounces each full scan of the keypad. Every confirmed press shifts a new
// nibble into a 16-bit value that goes to the seven-segment display driver.
module hex_keypad_scanner #(
    parameter int SCAN_DIV       = 50000,  // clocks per column slot, >= 4
    parameter int DEBOUNCE_SCANS = 4       // identical scans to confirm, >= 2
) (
    input  logic        clk,
    input  logic        reset,       // asynchronous, active-low
    input  logic [3:0]  row,         // active-low, asynchronous to clk
    output logic [3:0]  col,         // active-low one-hot column drive
    output logic [15:0] data,        // newest nibble in [3:0]
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held
);

    localparam int              PS_W     = $clog2(SCAN_DIV);
    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(SCAN_DIV - 1);
    localparam int              CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

    typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_REL} state_t;

    logic [3:0]       row_meta, row_sync;
    logic [PS_W-1:0]  prescaler;
    logic [1:0]       col_idx;
    logic             sample, scan_done;

    logic [1:0]       hits_acc;     // intersections so far this scan, 2 means "2 or more"
    logic [3:0]       acc_key;      // code of the first intersection seen this scan
    logic [3:0]       active;
    logic [2:0]       col_hits;
    logic [1:0]       row_idx;
    logic [2:0]       hits_sum;
    logic [3:0]       scan_key;
    logic             scan_none, scan_single;

    state_t           state, state_next;
    logic [3:0]       cand, cand_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             confirm;

    // Two-flop synchroniser; an idle row (all ones) is the safe reset value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // Prescaler and column index: one column slot every SCAN_DIV clocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
            col_idx   <= 2'd0;
        end else if (sample) begin
            prescaler <= '0;
            col_idx   <= col_idx + 2'd1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    assign sample    = (prescaler == PS_LAST);
    assign scan_done = sample && (col_idx == 2'd3);
    assign col       = ~(4'b0001 << col_idx);
    assign active    = ~row_sync;
    assign col_hits  = {2'b00, active[0]} + {2'b00, active[1]}
                     + {2'b00, active[2]} + {2'b00, active[3]};
    assign hits_sum  = {1'b0, hits_acc} + col_hits;

    // Lowest active row in the current column; only meaningful for a single hit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        row_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (active[i]) row_idx = 2'(i);
        end
    end

    assign scan_key    = (hits_acc == 2'd0) ? {row_idx, col_idx} : acc_key;
    assign scan_none   = (hits_sum == 3'd0);
    assign scan_single = (hits_sum == 3'd1);

    // Accumulate intersections over the four column samples of one scan.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hits_acc <= 2'd0;
            acc_key  <= 4'h0;
        end else if (scan_done) begin
            hits_acc <= 2'd0;
            acc_key  <= 4'h0;
        end else if (sample) begin
            hits_acc <= (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
            if (hits_acc == 2'd0 && col_hits == 3'd1) acc_key <= {row_idx, col_idx};
        end
    end

    // Debounce FSM state, candidate key and scan counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cand  <= 4'h0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cand  <= cand_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic; evaluated only when a full scan completes.
    always_comb begin
        state_next = state;
        cand_next  = cand;
        cnt_next   = cnt;
        confirm    = 1'b0;
        if (scan_done) begin
            unique case (state)
                IDLE: begin
                    if (scan_single) begin
                        cand_next  = scan_key;
                        cnt_next   = CNT_W'(1);
                        state_next = DEB_PRESS;
                    end
                end
                DEB_PRESS: begin
                    if (scan_single && scan_key == cand) begin
                        cnt_next = cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            confirm    = 1'b1;
                            state_next = PRESSED;
                        end
                    end else if (scan_single) begin
                        cand_next = scan_key;
                        cnt_next  = CNT_W'(1);
                    end else begin
                        state_next = IDLE;
                    end
                end
                PRESSED: begin
                    if (scan_none) begin
                        cnt_next   = CNT_W'(1);
                        state_next = DEB_REL;
                    end
                end
                DEB_REL: begin
                    if (scan_none) begin
                        cnt_next = cnt + 1'b1;
                        if (cnt == CNT_LAST) state_next = IDLE;
                    end else begin
                        state_next = PRESSED;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Confirmed press: one-clock pulse, latch the code, shift it into data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            data      <= 16'h0000;
        end else begin
            key_valid <= confirm;
            if (confirm) begin
                key_code <= cand;
                data     <= {data[11:0], cand};
            end
        end
    end

    assign key_held = (state == PRESSED) || (state == DEB_REL);

endmodule
